// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants, instruction fields and FSM state type for the memory stage
package proc_pkg;

  localparam int MAU_DATA_W = 16;
  localparam int MAU_ADDR_W = 16;
  localparam int INSTR_W    = 16;

  // Destination register field of the instruction word.
  localparam int DEST_HI = 10;
  localparam int DEST_LO = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mau_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating wait counter; expired flags the last permitted wait cycle
module mem_wait_timer
  import proc_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A miss in this cycle makes the count reach MAX_WAIT at the coming edge.
  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_unit2.sv
// rtl/mem_access_unit2.sv - memory-access stage: dmem req/ack with timeout, registered writeback bundle
module mem_access_unit2
  import proc_pkg::*;
#(
  parameter int DATA_W   = MAU_DATA_W,
  parameter int ADDR_W   = MAU_ADDR_W,
  parameter int MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [DATA_W-1:0]  ex_aluresult,
  input  logic [DATA_W-1:0]  ex_storeval,
  input  logic               ex_isld,
  input  logic               ex_isst,
  input  logic               ex_iswb,
  input  logic               flush,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ack,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               wb_valid,
  output logic               iswb,
  output logic               isld,
  output logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  ldresult,
  output logic [DATA_W-1:0]  aluresult,
  output logic               mem_err
);

  mau_state_e         state_q;
  logic               kill_q, kill_d;
  logic               lat_isld_q, lat_isst_q, lat_iswb_q;
  logic [INSTR_W-1:0] lat_instr_q;
  logic [DATA_W-1:0]  lat_alu_q, lat_wdata_q;
  logic               wb_valid_q, iswb_q, isld_q, mem_err_q;
  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  ldresult_q, aluresult_q;
  logic               in_wait, expired;

  assign in_wait = (state_q == MEM_WAIT);
  assign kill_d  = kill_q | flush;

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!in_wait),
    .en_i      (in_wait && !dmem_ack),
    .expired_o (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      lat_isld_q  <= 1'b0;
      lat_isst_q  <= 1'b0;
      lat_iswb_q  <= 1'b0;
      lat_instr_q <= '0;
      lat_alu_q   <= '0;
      lat_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      iswb_q      <= 1'b0;
      isld_q      <= 1'b0;
      mem_err_q   <= 1'b0;
      instr_q     <= '0;
      ldresult_q  <= '0;
      aluresult_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      mem_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid && !flush) begin
            if (ex_isld || ex_isst) begin
              state_q     <= MEM_WAIT;
              kill_q      <= 1'b0;
              lat_isld_q  <= ex_isld;
              lat_isst_q  <= ex_isst;
              lat_iswb_q  <= ex_iswb;
              lat_instr_q <= ex_instr;
              lat_alu_q   <= ex_aluresult;
              lat_wdata_q <= ex_storeval;
            end else begin
              wb_valid_q  <= 1'b1;
              iswb_q      <= ex_iswb;
              isld_q      <= 1'b0;
              instr_q     <= ex_instr;
              ldresult_q  <= '0;
              aluresult_q <= ex_aluresult;
            end
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
            // A squashed instruction still finishes on the bus but never retires.
            if (!kill_d) begin
              wb_valid_q  <= 1'b1;
              iswb_q      <= lat_iswb_q && !lat_isst_q;
              isld_q      <= lat_isld_q;
              instr_q     <= lat_instr_q;
              ldresult_q  <= lat_isld_q ? dmem_rdata : '0;
              aluresult_q <= lat_alu_q;
            end
          end else if (expired) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            mem_err_q <= 1'b1;
          end else begin
            kill_q <= kill_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = in_wait;
  assign dmem_req   = in_wait;
  assign dmem_we    = in_wait && lat_isst_q;
  assign dmem_addr  = lat_alu_q[ADDR_W-1:0];
  assign dmem_wdata = lat_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign iswb       = iswb_q;
  assign isld       = isld_q;
  assign instr      = instr_q;
  assign ldresult   = ldresult_q;
  assign aluresult  = aluresult_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_unit2.sv
// tb/tb_mem_access_unit2.sv - randomized self-checking bench with transaction-level reference model
module tb_mem_access_unit2;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MW = 4;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_FL = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid, ex_isld, ex_isst, ex_iswb, flush;
  logic [15:0]   ex_instr;
  logic [DW-1:0] ex_aluresult, ex_storeval;
  logic          stall, dmem_req, dmem_we, dmem_ack;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          wb_valid, iswb, isld, mem_err;
  logic [15:0]   instr;
  logic [DW-1:0] ldresult, aluresult;

  mem_access_unit2 #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_aluresult(ex_aluresult),
    .ex_storeval(ex_storeval), .ex_isld(ex_isld), .ex_isst(ex_isst),
    .ex_iswb(ex_iswb), .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .iswb(iswb), .isld(isld), .instr(instr),
    .ldresult(ldresult), .aluresult(aluresult), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Last retired bundle; outputs must hold it while wb_valid is low.
  logic          exp_iswb, exp_isld;
  logic [15:0]   exp_instr;
  logic [DW-1:0] exp_ld, exp_alu;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_bundle(input string tag);
    chk({tag, ".iswb"}, 32'(iswb), 32'(exp_iswb));
    chk({tag, ".isld"}, 32'(isld), 32'(exp_isld));
    chk({tag, ".instr"}, 32'(instr), 32'(exp_instr));
    chk({tag, ".ldresult"}, 32'(ldresult), 32'(exp_ld));
    chk({tag, ".aluresult"}, 32'(aluresult), 32'(exp_alu));
  endtask

  // kind: ALU/LD/ST/flushed-in-idle; d: wait cycle carrying ack (beyond MW = never);
  // f: wait cycle carrying flush (0 = none). Entered and left at posedge+1.
  task automatic run_op(input int kind, input logic [15:0] ins, input logic [DW-1:0] alu,
                        input logic [DW-1:0] sv, input logic wbf, input int d, input int f);
    logic ok, killed;
    logic [DW-1:0] rd;
    ok = 1'b0;
    killed = 1'b0;
    rd = '0;
    ex_valid     = 1'b1;
    ex_instr     = ins;
    ex_aluresult = alu;
    ex_storeval  = sv;
    ex_isld      = (kind == K_LD);
    ex_isst      = (kind == K_ST);
    ex_iswb      = wbf;
    flush        = (kind == K_FL);
    dmem_ack     = 1'($urandom);
    dmem_rdata   = 16'($urandom);
    @(negedge clk);
    chk("idle.stall", 32'(stall), 32'd0);
    chk("idle.req", 32'(dmem_req), 32'd0);
    chk("pulse.wb_valid", 32'(wb_valid), 32'd0);
    chk("pulse.mem_err", 32'(mem_err), 32'd0);
    @(posedge clk); #1;
    ex_valid     = 1'b0;
    flush        = 1'b0;
    dmem_ack     = 1'b0;
    ex_instr     = 16'($urandom);
    ex_aluresult = 16'($urandom);
    ex_storeval  = 16'($urandom);
    if (kind == K_ALU) begin
      exp_iswb  = wbf;
      exp_isld  = 1'b0;
      exp_instr = ins;
      exp_ld    = '0;
      exp_alu   = alu;
      @(negedge clk);
      chk("alu.wb_valid", 32'(wb_valid), 32'd1);
      chk("alu.stall", 32'(stall), 32'd0);
      check_bundle("alu");
    end else if (kind == K_FL) begin
      @(negedge clk);
      chk("flushed.wb_valid", 32'(wb_valid), 32'd0);
      chk("flushed.stall", 32'(stall), 32'd0);
      check_bundle("flushed.hold");
    end else begin
      for (int k = 1; k <= MW; k++) begin
        dmem_ack   = (k == d);
        dmem_rdata = 16'($urandom);
        rd         = dmem_rdata;
        flush      = (k == f);
        if (k == f) killed = 1'b1;
        @(negedge clk);
        chk("wait.stall", 32'(stall), 32'd1);
        chk("wait.req", 32'(dmem_req), 32'd1);
        chk("wait.we", 32'(dmem_we), 32'(kind == K_ST));
        chk("wait.addr", 32'(dmem_addr), 32'(alu));
        chk("wait.wdata", 32'(dmem_wdata), 32'(sv));
        chk("wait.wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        flush    = 1'b0;
        if (k == d) begin
          ok = 1'b1;
          break;
        end
      end
      if (ok && !killed) begin
        exp_iswb  = (kind == K_LD) ? wbf : 1'b0;
        exp_isld  = (kind == K_LD);
        exp_instr = ins;
        exp_ld    = (kind == K_LD) ? rd : '0;
        exp_alu   = alu;
      end
      @(negedge clk);
      chk("done.stall", 32'(stall), 32'd0);
      chk("done.req", 32'(dmem_req), 32'd0);
      chk("done.mem_err", 32'(mem_err), 32'(!ok));
      chk("done.wb_valid", 32'(wb_valid), 32'(ok && !killed));
      check_bundle("done");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_isld = 1'b0; ex_isst = 1'b0; ex_iswb = 1'b0; flush = 1'b0;
    ex_instr = '0; ex_aluresult = '0; ex_storeval = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_iswb = 1'b0; exp_isld = 1'b0; exp_instr = '0; exp_ld = '0; exp_alu = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.wb_valid", 32'(wb_valid), 32'd0);
    chk("rst.mem_err", 32'(mem_err), 32'd0);
    check_bundle("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(K_ALU, 16'h0A00, 16'h1234, 16'h0000, 1'b1, 0, 0);
    run_op(K_LD,  16'h0B11, 16'h0040, 16'h0000, 1'b1, 3, 0);
    run_op(K_ST,  16'h0C22, 16'h0010, 16'h5A5A, 1'b1, 1, 0);
    run_op(K_LD,  16'h0D33, 16'h0050, 16'h0000, 1'b1, 4, 2);
    run_op(K_ALU, 16'h0E44, 16'h7777, 16'h0000, 1'b1, 0, 0);
    run_op(K_LD,  16'h0F55, 16'h0060, 16'h0000, 1'b1, MW + 1, 0);
    run_op(K_ST,  16'h0166, 16'h0070, 16'hA5A5, 1'b0, MW + 1, 0);
    run_op(K_LD,  16'h0277, 16'h0080, 16'h0000, 1'b1, MW, MW);
    run_op(K_FL,  16'h0388, 16'h9999, 16'h0000, 1'b1, 0, 0);

    // Reset in the middle of a wait, then an ADD must complete in one cycle.
    ex_valid = 1'b1; ex_isld = 1'b1; ex_isst = 1'b0; ex_iswb = 1'b1;
    ex_instr = 16'h0499; ex_aluresult = 16'h00F0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    chk("midrst.stall_before", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.req", 32'(dmem_req), 32'd0);
    chk("midrst.stall", 32'(stall), 32'd0);
    chk("midrst.we", 32'(dmem_we), 32'd0);
    chk("midrst.addr", 32'(dmem_addr), 32'd0);
    chk("midrst.wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst.mem_err", 32'(mem_err), 32'd0);
    exp_iswb = 1'b0; exp_isld = 1'b0; exp_instr = '0; exp_ld = '0; exp_alu = '0;
    check_bundle("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(K_ALU, 16'h0A00, 16'h4321, 16'h0000, 1'b1, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int kind, d, f;
      kind = int'($urandom_range(0, 3));
      d = int'($urandom_range(1, MW + 2));
      f = 0;
      if (kind == K_LD && ($urandom_range(0, 2) == 0)) f = int'($urandom_range(1, (d > MW) ? MW : d));
      run_op(kind, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), d, f);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
